pipelined_prefix_adder: RTL and testbench
=========================================

# pipelined_prefix_adder

Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor with valid/ready handshaking. It is the final carry-propagate stage behind the Wallace-tree multiplier, and it is also shared with ALU paths that need a wide, fast add. Width, pipeline depth and sideband tag width are configurable. It adds subtract mode, carry-in, carry-out, signed-overflow and zero flags, and backpressure that stalls the whole pipe.

## Interface
Parameters:
- WIDTH, 64: operand and sum width; power of two, 8..128.
- STAGES, 2: pipeline register slices, 1..4; equals the latency in cycles.
- TAG_W, 5: sideband tag width (e.g. destination register index), ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used in ADD mode only.
- sub  in  1  0 = ADD (a+b+cin), 1 = SUB (a-b).
- tag_in  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1; in SUB, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.
- tag_out  out  TAG_W  tag of the current result.

## Operation
- Operand preparation:
  - ADD: b_eff = b, c0 = cin.
  - SUB: b_eff = ~b, c0 = 1; cin is ignored.
- Generate/propagate:
  - G = a & b_eff, P = a | b_eff, X = a ^ b_eff.
  - The bit-0 carry-in is folded in as G0' = G[0] | (P[0] & c0).
- Prefix network:
  - L = log2(WIDTH) Kogge-Stone levels; level k uses span 2^(k-1).
  - Each level combines with (G, P) from bit i-span; bits i < span pass through unchanged.
- Carries and result:
  - Carry into bit i is Gpre[i-1] for i ≥ 1, and c0 for i = 0.
  - sum = X ^ carry vector.
  - cout = Gpre[WIDTH-1].
  - ovf = carry-into-MSB ^ cout.
  - zero = ~|sum.
- Register placement:
  - Slice s (1..STAGES) sits after prefix level ceil(s·L/STAGES).
  - Slice STAGES is always the output register, after the sum/flag logic.
  - Each slice holds its valid bit, the intermediate G/P/X, c0 and the tag.
- Handshake (global stall):
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall & ~rst.
  - While stall, every slice holds its contents.
  - Otherwise every slice advances one step; slice 1 loads the input beat, with valid = in_valid & in_ready.
  - Bubbles are not compressed.
- Flush:
  - Clears every valid bit at the next edge. Data registers keep their values.
  - A beat presented in the same cycle as flush is dropped.
  - Flush overrides stall.
- Reset:
  - All valid bits are 0.
  - sum, cout, ovf, zero and tag_out are 0; zero reads 0 during reset.
  - in_ready is 0 while rst is high.
  - An operation in flight when reset is asserted is discarded and produces no output.
- Output stability: while out_valid & ~out_ready, all result outputs must stay stable.

## Timing
- Latency: a beat accepted at edge t gives out_valid=1 with its result after edge t+STAGES-1, i.e. in cycle t+STAGES.
- Throughput: one result per cycle when out_ready is held high.
- Ordering: results leave in strict acceptance order.
- Simultaneous in_valid and out_ready while full: accepted in the same cycle, with no bubble inserted.
- out_ready low for N cycles: the pipe freezes for N cycles; no beat is lost or duplicated.
- Output dependencies: outputs depend only on registers (output registered).
- Combinational paths: in_ready depends combinationally on out_ready; no other input-to-output combinational path exists.
- Critical path: at most ceil(L/STAGES)+1 prefix levels per slice.

## Test plan
- Basic add, WIDTH=64, STAGES=2: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, tag=3 → two cycles later sum=0, cout=1, zero=1, ovf=0, tag_out=3.
- Subtract: a=5, b=7, sub=1 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), ovf=0. Then a=0x8000_0000_0000_0000, b=1, sub=1 → sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Carry-in and signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0x8000_0000_0000_0000, ovf=1. Repeat with sub=1 and cin=1 to check that cin is ignored.
- Backpressure: stream 10 random beats with in_valid=1 while out_ready toggles in the pattern 1,0,0,1,… → all 10 results equal the reference model, in order, with no loss or duplication. Outputs stay stable during stall cycles.
- Flush/reset mid-flight:
  - Accept 2 beats, assert flush for 1 cycle → no out_valid for them; a new beat accepted afterwards appears with normal latency.
  - Same sequence with rst instead of flush → all outputs read 0 after reset.
- Parameter sweep: WIDTH ∈ {8, 32, 64, 128} × STAGES ∈ {1, 2, 3, 4}, 10k random beats each against a behavioural model → exact match; measured latency equals STAGES.

Source files
------------

// File: rtl/pipelined_prefix_adder.sv
// Kogge-Stone parallel-prefix adder/subtractor with a tag sideband and sum/carry/overflow/zero flags.
// Latency: STAGES cycles (register slices cut the prefix network; the last slice registers the result).
// Backpressure: out_valid & ~out_ready freezes every slice; in_ready drops the same cycle.
module pipelined_prefix_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] tag_out
);

    localparam int L = $clog2(WIDTH);

    // Prefix level after which slice s is cut: ceil(s*L/STAGES).
    function automatic int cut_level(input int s);
        return (s * L + STAGES - 1) / STAGES;
    endfunction

    // Boundary state between slices: index 0 is the prepared input beat,
    // index s is the content of register slice s (s < STAGES).
    logic [WIDTH-1:0] w_bg   [0:STAGES-1];
    logic [WIDTH-1:0] w_bp   [0:STAGES-1];
    logic [WIDTH-1:0] w_bx   [0:STAGES-1];
    logic             w_bc0  [0:STAGES-1];
    logic             w_bvld [0:STAGES-1];
    logic [TAG_W-1:0] w_btag [0:STAGES-1];

    logic             r_out_vld;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic [TAG_W-1:0] r_tag_out;

    logic             w_stall;
    logic [WIDTH-1:0] w_beff;
    logic             w_c0;
    logic [WIDTH-1:0] w_g0;

    assign w_stall  = r_out_vld & ~out_ready;
    assign in_ready = ~w_stall & ~rst;

    // SUB is a + ~b + 1, so cin only matters in ADD mode.
    assign w_beff = sub ? ~b : b;
    assign w_c0   = sub | cin;
    // Fold the carry-in into bit 0 so the prefix network yields true carries directly.
    assign w_g0   = {a[WIDTH-1:1] & w_beff[WIDTH-1:1],
                     (a[0] & w_beff[0]) | ((a[0] | w_beff[0]) & w_c0)};

    assign w_bg[0]   = w_g0;
    assign w_bp[0]   = a | w_beff;
    assign w_bx[0]   = a ^ w_beff;
    assign w_bc0[0]  = w_c0;
    assign w_bvld[0] = in_valid & in_ready;
    assign w_btag[0] = tag_in;

    for (genvar s = 1; s <= STAGES; s++) begin : g_slice
        localparam int LO = cut_level(s - 1);
        localparam int NL = cut_level(s) - LO;

        logic [WIDTH-1:0] w_lg [0:NL];
        logic [WIDTH-1:0] w_lp [0:NL];

        assign w_lg[0] = w_bg[s-1];
        assign w_lp[0] = w_bp[s-1];

        for (genvar j = 1; j <= NL; j++) begin : g_lvl
            localparam int SPAN = 1 << (LO + j - 1);
            logic [WIDTH-1:0] w_g;
            logic [WIDTH-1:0] w_p;
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (i >= SPAN) begin : g_comb
                    assign w_g[i] = w_lg[j-1][i] | (w_lp[j-1][i] & w_lg[j-1][i-SPAN]);
                    assign w_p[i] = w_lp[j-1][i] & w_lp[j-1][i-SPAN];
                end else begin : g_pass
                    assign w_g[i] = w_lg[j-1][i];
                    assign w_p[i] = w_lp[j-1][i];
                end
            end
            assign w_lg[j] = w_g;
            assign w_lp[j] = w_p;
        end

        if (s < STAGES) begin : g_mid
            logic [WIDTH-1:0] r_g;
            logic [WIDTH-1:0] r_p;
            logic [WIDTH-1:0] r_x;
            logic             r_c0;
            logic             r_vld;
            logic [TAG_W-1:0] r_tag;

            // Intermediate slice: advance unless stalled; flush only kills the valid bit.
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    r_vld <= 1'b0;
                end else if (!w_stall) begin
                    r_vld <= w_bvld[s-1];
                    r_g   <= w_lg[NL];
                    r_p   <= w_lp[NL];
                    r_x   <= w_bx[s-1];
                    r_c0  <= w_bc0[s-1];
                    r_tag <= w_btag[s-1];
                end
            end

            assign w_bg[s]   = r_g;
            assign w_bp[s]   = r_p;
            assign w_bx[s]   = r_x;
            assign w_bc0[s]  = r_c0;
            assign w_bvld[s] = r_vld;
            assign w_btag[s] = r_tag;
        end else begin : g_out
            logic [WIDTH-1:0] w_carry;
            logic [WIDTH-1:0] w_sum;
            logic             w_cout;

            assign w_carry = {w_lg[NL][WIDTH-2:0], w_bc0[s-1]};
            assign w_sum   = w_bx[s-1] ^ w_carry;
            assign w_cout  = w_lg[NL][WIDTH-1];

            // Output slice: registered result and flags, cleared to zero by reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_vld <= 1'b0;
                    r_sum     <= '0;
                    r_cout    <= 1'b0;
                    r_ovf     <= 1'b0;
                    r_zero    <= 1'b0;
                    r_tag_out <= '0;
                end else if (flush) begin
                    r_out_vld <= 1'b0;
                end else if (!w_stall) begin
                    r_out_vld <= w_bvld[s-1];
                    r_sum     <= w_sum;
                    r_cout    <= w_cout;
                    r_ovf     <= w_carry[WIDTH-1] ^ w_cout;
                    r_zero    <= ~|w_sum;
                    r_tag_out <= w_btag[s-1];
                end
            end
        end
    end

    assign out_valid = r_out_vld;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign tag_out   = r_tag_out;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed and backpressure bench for pipelined_prefix_adder (WIDTH=64, STAGES=2).
// Vectors carry hand-computed results; the streaming test uses a wide-arithmetic model.
// Every wait on the DUT is bounded by a cycle budget.
module tb_pipelined_prefix_adder;
    localparam int W = 64;
    localparam int S = 2;
    localparam int T = 5;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, cin, sub, out_valid, out_ready;
    logic         cout, ovf, zero;
    logic [W-1:0] a, b, sum;
    logic [T-1:0] tag_in, tag_out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [T-1:0] tag;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        logic         ez;
    } vec_t;

    vec_t vt [10];
    vec_t exp_q [$];

    pipelined_prefix_adder #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                   input logic xcin, input logic xsub, input logic [T-1:0] xtag);
        vec_t v;
        logic [W-1:0] be;
        logic [W:0]   r;
        be = xsub ? ~xb : xb;
        r  = {1'b0, xa} + {1'b0, be} + {{W{1'b0}}, (xsub | xcin)};
        v.a = xa; v.b = xb; v.cin = xcin; v.sub = xsub; v.tag = xtag;
        v.es = r[W-1:0];
        v.ec = r[W];
        v.eo = (xa[W-1] == be[W-1]) && (r[W-1] != xa[W-1]);
        v.ez = (r[W-1:0] == '0);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub; tag_in = v.tag;
    endtask

    task automatic check_result(input string nm, input vec_t v);
        chk({nm, ".sum"},  sum,     v.es);
        chk({nm, ".cout"}, cout,    v.ec);
        chk({nm, ".ovf"},  ovf,     v.eo);
        chk({nm, ".zero"}, zero,    v.ez);
        chk({nm, ".tag"},  tag_out, v.tag);
    endtask

    // One beat through an otherwise empty pipe, measuring latency in cycles.
    task automatic run_one(input string nm, input vec_t v);
        int cnt;
        @(negedge clk);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({nm, ".in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            cnt++;
            if (out_valid) break;
        end
        chk({nm, ".latency"}, cnt, S);
        if (out_valid) check_result(nm, v);
    endtask

    task automatic count_valids(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) n++;
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, ".in_ready"},  in_ready,  1'b0);
        chk({nm, ".out_valid"}, out_valid, 1'b0);
        chk({nm, ".sum"},       sum,       '0);
        chk({nm, ".cout"},      cout,      1'b0);
        chk({nm, ".ovf"},       ovf,       1'b0);
        chk({nm, ".zero"},      zero,      1'b0);
        chk({nm, ".tag"},       tag_out,   '0);
    endtask

    initial begin
        int n;
        vec_t cur, fr;
        logic have_cur, held, acc;
        logic [W-1:0] h_sum;
        logic [T-1:0] h_tag;
        logic         h_flags [3];
        int sent, got, cyc;

        //            a                        b                        cin   sub   tag    sum                      cout  ovf   zero
        vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                   1'b0, 1'b0, 5'd3,  64'h0,                   1'b1, 1'b0, 1'b1};
        vt[1] = '{64'h5,                   64'h7,                   1'b0, 1'b1, 5'd1,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vt[2] = '{64'h8000_0000_0000_0000, 64'h1,                   1'b0, 1'b1, 5'd2,  64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0};
        vt[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0,                   1'b1, 1'b0, 5'd4,  64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
        vt[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0,                   1'b1, 1'b1, 5'd5,  64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vt[5] = '{64'h5,                   64'h5,                   1'b0, 1'b1, 5'd6,  64'h0,                   1'b1, 1'b0, 1'b1};
        vt[6] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 5'd7,  64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0};
        vt[7] = '{64'h0,                   64'h0,                   1'b1, 1'b0, 5'd31, 64'h1,                   1'b0, 1'b0, 1'b0};
        vt[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 5'd8,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        vt[9] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 5'd9,  64'h0,                   1'b1, 1'b1, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag_in = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_one($sformatf("vec%0d", i), vt[i]);

        // Streaming with out_ready pattern 1,0,0 repeating.
        sent = 0; got = 0; cyc = 0; have_cur = 1'b0; held = 1'b0;
        h_sum = '0; h_tag = '0; h_flags = '{1'b0, 1'b0, 1'b0};
        while (got < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            out_ready = (cyc % 3 == 1);
            if (sent < 10 && !have_cur) begin
                cur = model({$urandom, $urandom}, {$urandom, $urandom},
                            1'($urandom % 2), 1'($urandom % 2), T'(sent));
                have_cur = 1'b1;
            end
            in_valid = have_cur;
            if (have_cur) drive(cur);
            #1;
            if (held) begin
                chk("stall.valid_hold", out_valid, 1'b1);
                chk("stall.sum_hold",   sum, h_sum);
                chk("stall.tag_hold",   tag_out, h_tag);
                chk("stall.flag_hold",  {cout, ovf, zero}, {h_flags[0], h_flags[1], h_flags[2]});
            end
            held = out_valid & ~out_ready;
            if (held) begin
                h_sum = sum; h_tag = tag_out; h_flags = '{cout, ovf, zero};
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream.unexpected_result", 1'b1, 1'b0);
                end else begin
                    fr = exp_q.pop_front();
                    check_result($sformatf("stream%0d", got), fr);
                end
                got++;
            end
            acc = in_valid & in_ready;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(cur);
                sent++;
                have_cur = 1'b0;
            end
        end
        chk("stream.count", got, 10);
        #1 in_valid = 1'b0; out_ready = 1'b1;
        count_valids(6, n);
        chk("stream.no_duplicate", n, 0);

        // Flush: one beat in flight plus one beat presented alongside flush.
        @(negedge clk);
        drive(vt[6]); in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drive(vt[7]); flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        count_valids(6, n);
        chk("flush.no_output", n, 0);
        run_one("post_flush", vt[2]);

        // Reset with a beat in flight.
        @(negedge clk);
        drive(vt[3]); in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        count_valids(6, n);
        chk("midreset.no_output", n, 0);
        run_one("post_reset", vt[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
